// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, shared tick prescaler and tick-qualified debouncer with edge pulses
module debounce_bank #(
  parameter int                  CHANNELS     = 4,
  parameter int                  TICK_BITS    = 17,
  parameter int                  STABLE_TICKS = 3,
  parameter int                  SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [TICK_BITS-1:0]                 r_pre;
  logic [CW-1:0]                        r_cnt [CHANNELS];
  logic [CHANNELS-1:0]                  w_s;
  logic [CHANNELS-1:0]                  w_diff;
  logic [CHANNELS-1:0]                  w_load;
  logic [CHANNELS-1:0]                  w_rise;
  logic [CHANNELS-1:0]                  w_fall;
  logic                                 w_tick;
  assign w_s    = r_sync[SYNC_STAGES-1] ^ INVERT;
  assign w_diff = w_s ^ level;
  assign w_tick = &r_pre;
  assign w_rise = w_load & w_s;
  assign w_fall = w_load & ~w_s;
  // shift raw inputs through the synchroniser chain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], signal};
  end
  // free-running prescaler; tick is its all-ones state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_pre <= '0;
    else        r_pre <= r_pre + 1'b1;
  end
  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      assign w_load[g] = w_diff[g] & w_tick & (r_cnt[g] == LAST);
      // agreement or acceptance clears, disagreement counts ticks, otherwise hold
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_cnt[g] <= '0;
        else        r_cnt[g] <= (!w_diff[g] || w_load[g]) ? '0 : w_tick ? r_cnt[g] + 1'b1 : r_cnt[g];
      end
    end
  endgenerate
  // accept qualified levels and register the matching edge pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level      <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      level      <= level ^ w_load;
      rise       <= w_rise;
      fall       <= w_fall;
      any_change <= |(w_rise | w_fall);
    end
  end
endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent input channels.
REQ-002 The block SHALL have parameter TICK_BITS, default 17, prescaler width; one tick every 2^TICK_BITS clocks.
REQ-003 The block SHALL have parameter STABLE_TICKS, default 3, consecutive ticks of disagreement required to accept a new level (legal range 1..15).
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (legal range 2..4).
REQ-005 The block SHALL have parameter INVERT, default all-zero, CHANNELS-bit mask; a set bit inverts that channel after synchronisation (active-low keys).
REQ-006 The block SHALL have port clock, input, 1, single clock for all logic.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port signal, input, CHANNELS, raw asynchronous inputs.
REQ-009 The block SHALL have port level, output, CHANNELS, debounced registered level.
REQ-010 The block SHALL have port rise, output, CHANNELS, one-cycle pulse when level goes 0->1.
REQ-011 The block SHALL have port fall, output, CHANNELS, one-cycle pulse when level goes 1->0.
REQ-012 The block SHALL have port any_change, output, 1, OR of all rise and fall bits, registered in the same cycle as them.

Function
REQ-013 The block SHALL pass each signal bit through SYNC_STAGES flops, then XOR with INVERT, giving s[i].
REQ-014 The block SHALL keep one shared TICK_BITS prescaler incrementing every clock and wrapping from all-ones to 0.
REQ-015 The block SHALL assert tick combinationally in exactly those cycles where the prescaler is all-ones.
REQ-016 The block SHALL keep per channel a counter c[i] of width ceil(log2(STABLE_TICKS+1)).
REQ-017 If s[i]==level[i], the block SHALL clear c[i] to 0 on that clock, tick or not; any bounce back restarts qualification.
REQ-018 If s[i]!=level[i] and tick and c[i]==STABLE_TICKS-1, the block SHALL load level[i]<=s[i] and clear c[i] on that clock.
REQ-019 If s[i]!=level[i] and tick and c[i]<STABLE_TICKS-1, the block SHALL increment c[i].
REQ-020 If s[i]!=level[i] and no tick, the block SHALL hold c[i].
REQ-021 The block SHALL register rise[i]/fall[i] high for exactly the one cycle after level[i] changes, and low otherwise.
REQ-022 The block SHALL process channels independently; simultaneous qualification on several channels SHALL update all of them in the same cycle.
REQ-023 The block SHALL give a qualification latency, from s[i] change to level[i] change, of between (STABLE_TICKS-1)*2^TICK_BITS+1 and STABLE_TICKS*2^TICK_BITS clocks.
REQ-024 Prescaler wrap SHALL have no effect beyond tick generation; counters never wrap (maximum value STABLE_TICKS-1).

Reset
REQ-025 Asserting reset low SHALL immediately, without a clock, clear the synchronisers, prescaler, all c[i], level, rise, fall and any_change to 0.
REQ-026 Reset asserted mid-qualification SHALL discard progress and produce no rise or fall pulse on or after release.
REQ-027 After release, a channel whose s[i] is 1 (raw 0 with INVERT set, or raw 1 without) SHALL qualify normally and produce one rise pulse.

Verification (CHANNELS=4, TICK_BITS=2, STABLE_TICKS=3, SYNC_STAGES=2, INVERT=4'b0000 unless stated)
REQ-028 Test 1: signal[0] held 1 from reset release -> level[0]=1 within 9..12 clocks after s[0]=1, with rise[0] and any_change high for exactly 1 cycle.
REQ-029 Test 2: signal[1] toggles 1/0 every 3 clocks for 40 clocks -> level[1] stays 0 and rise[1] never asserts.
REQ-030 Test 3: level[2]=1, then signal[2]=0 for 6 clocks, then 1 -> level[2] stays 1, no fall pulse; signal[2]=0 held -> fall[2] pulses once.
REQ-031 Test 4: signal[0] and signal[3] rise on the same clock -> level[0] and level[3] change on the same clock, with one any_change pulse.
REQ-032 Test 5: INVERT=4'b0001, signal[0]=1 held -> level[0]=0 permanently; signal[0] driven 0 -> rise[0] after qualification.
REQ-033 Test 6: reset pulsed low for 1 clock at c[0]=2 -> all outputs 0 asynchronously, and requalification takes the full 9..12 clocks.
